// File: rtl/snd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snd_bus_sequencer
// Brief    : Posted-write FIFO plus timed replay onto the shared YM2203/SAA1099
//            sound bus. Optional RECOVER state: SND_BUS_SEQ_RECOVERY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module snd_bus_sequencer #(
    parameter int DEPTH_LOG2   = 2,
    parameter int SETUP_CYC    = 3,
    parameter int STROBE_CYC   = 8,
    parameter int HOLD_CYC     = 3,
    parameter int RECOVERY_CYC = 16
) (
    input  logic       clk32,
    input  logic       rst_n,
    input  logic       req_wr,
    input  logic [1:0] req_dev,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       req_rdy,
    output logic       busy,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       aa0,
    output logic       n_awr,
    output logic       n_ym1_cs,
    output logic       n_ym2_cs,
    output logic       n_saa_cs
);

    localparam int                  c_depth     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full      = (DEPTH_LOG2 + 1)'(c_depth);
    localparam logic [DEPTH_LOG2:0] c_cnt_one   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);
    localparam logic [5:0]          c_setup_ld  = 6'(SETUP_CYC - 1);
    localparam logic [5:0]          c_strobe_ld = 6'(STROBE_CYC - 1);
    localparam logic [5:0]          c_hold_ld   = 6'(HOLD_CYC - 1);
`ifdef SND_BUS_SEQ_RECOVERY_EN
    localparam logic [5:0]          c_recover_ld = 6'(RECOVERY_CYC - 1);
`endif

    if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15 || RECOVERY_CYC < 1 || RECOVERY_CYC > 63)
    begin : g_param_check
        $error("snd_bus_sequencer: timing parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3
`ifdef SND_BUS_SEQ_RECOVERY_EN
        , S_RECOVER = 3'd4
`endif
    } state_t;

    // FIFO entry layout: {dev[1:0], a0, data[7:0]}
    logic [10:0]           r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic [10:0]           w_head;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_cs, w_cs_nxt;          // {saa, ym2, ym1}, active low
    logic [7:0] r_ad, w_ad_nxt;
    logic       r_oe, w_oe_nxt;
    logic       r_aa0, w_aa0_nxt;
    logic       r_nawr, w_nawr_nxt;

    assign w_full  = (r_count == c_full);
    assign w_empty = (r_count == '0);
    assign w_push  = req_wr && (req_dev != 2'd3) && !w_full;
    // Fullness is judged before any same-edge pop, so a request at full is lost.
    assign w_drop  = req_wr && (req_dev != 2'd3) && w_full;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk32) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_dev, req_a0, req_data};
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cs    <= 3'b111;
            r_ad    <= '0;
            r_oe    <= 1'b0;
            r_aa0   <= 1'b0;
            r_nawr  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cs    <= w_cs_nxt;
            r_ad    <= w_ad_nxt;
            r_oe    <= w_oe_nxt;
            r_aa0   <= w_aa0_nxt;
            r_nawr  <= w_nawr_nxt;
        end
    end

`ifdef SND_BUS_SEQ_RECOVERY_EN
    logic w_ym_data;
    // The latched CS and aa0 already identify a YM data-port write.
    assign w_ym_data = (!r_cs[0] || !r_cs[1]) && r_aa0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_cs_nxt    = r_cs;
        w_ad_nxt    = r_ad;
        w_oe_nxt    = r_oe;
        w_aa0_nxt   = r_aa0;
        w_nawr_nxt  = r_nawr;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = c_setup_ld;
                    w_ad_nxt    = w_head[7:0];
                    w_aa0_nxt   = w_head[8];
                    w_oe_nxt    = 1'b1;
                    w_nawr_nxt  = 1'b1;
                    case (w_head[10:9])
                        2'd0:    w_cs_nxt = 3'b110;
                        2'd1:    w_cs_nxt = 3'b101;
                        2'd2:    w_cs_nxt = 3'b011;
                        default: w_cs_nxt = 3'b111;
                    endcase
                end
            end
            S_SETUP: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = c_strobe_ld;
                    w_nawr_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            S_STROBE: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_hold_ld;
                    w_nawr_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 6'd0) begin
                    w_cs_nxt    = 3'b111;
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
`ifdef SND_BUS_SEQ_RECOVERY_EN
                    if (w_ym_data) begin
                        w_state_nxt = S_RECOVER;
                        w_cnt_nxt   = c_recover_ld;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
`ifdef SND_BUS_SEQ_RECOVERY_EN
            S_RECOVER: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req_rdy  = !w_full;
    assign busy     = !w_empty || (r_state != S_IDLE);
    assign ovf      = r_ovf;
    assign ad_out   = r_ad;
    assign ad_oe    = r_oe;
    assign aa0      = r_aa0;
    assign n_awr    = r_nawr;
    assign n_ym1_cs = r_cs[0];
    assign n_ym2_cs = r_cs[1];
    assign n_saa_cs = r_cs[2];

endmodule
`default_nettype wire

// File: tb/tb_snd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snd_bus_sequencer
// Brief    : Self-checking bench: timeline model of queued bus cycles plus
//            directed literal checks. Honours SND_BUS_SEQ_RECOVERY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snd_bus_sequencer;

    localparam int c_depth = 4;
    localparam int c_s     = 3;
    localparam int c_st    = 8;
    localparam int c_h     = 3;
    localparam int c_r     = 16;
`ifdef SND_BUS_SEQ_RECOVERY_EN
    localparam bit c_rec_en = 1'b1;
`else
    localparam bit c_rec_en = 1'b0;
`endif

    logic       clk32 = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_wr = 1'b0;
    logic [1:0] req_dev = 2'd0;
    logic       req_a0 = 1'b0;
    logic [7:0] req_data = 8'd0;
    logic       ovf_clr = 1'b0;
    logic       req_rdy, busy, ovf, ad_oe, aa0, n_awr;
    logic       n_ym1_cs, n_ym2_cs, n_saa_cs;
    logic [7:0] ad_out;

    snd_bus_sequencer #(
        .DEPTH_LOG2  (2),
        .SETUP_CYC   (c_s),
        .STROBE_CYC  (c_st),
        .HOLD_CYC    (c_h),
        .RECOVERY_CYC(c_r)
    ) dut (
        .clk32   (clk32),
        .rst_n   (rst_n),
        .req_wr  (req_wr),
        .req_dev (req_dev),
        .req_a0  (req_a0),
        .req_data(req_data),
        .req_rdy (req_rdy),
        .busy    (busy),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .aa0     (aa0),
        .n_awr   (n_awr),
        .n_ym1_cs(n_ym1_cs),
        .n_ym2_cs(n_ym2_cs),
        .n_saa_cs(n_saa_cs)
    );

    always #5 clk32 = ~clk32;

    typedef struct {
        int dev;
        int a0;
        int data;
    } ent_t;

    ent_t mq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   cur_valid = 1'b0;
    int   cur_start = 0, cur_dev = 0, cur_a0 = 0, cur_data = 0;
    int   free_edge = 0;
    bit   m_ovf = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int rec_gap(input int dev, input int a0);
        return (c_rec_en && dev < 2 && a0 == 1) ? c_r : 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        cur_valid = 1'b0;
        free_edge = 0;
        m_ovf     = 1'b0;
    endtask

    // One clock edge: a start uses the queue as it stood before the edge, and
    // fullness for a new request is also judged on that pre-edge occupancy.
    task automatic model_edge();
        int   pre;
        ent_t e;
        pre = mq.size();
        if (cyc >= free_edge && pre > 0) begin
            e = mq.pop_front();
            cur_valid = 1'b1;
            cur_start = cyc;
            cur_dev   = e.dev;
            cur_a0    = e.a0;
            cur_data  = e.data;
            free_edge = cyc + c_s + c_st + c_h + 1 + rec_gap(e.dev, e.a0);
        end
        if (req_wr && req_dev != 2'd3 && pre == c_depth) begin
            m_ovf = 1'b1;
        end else begin
            if (req_wr && req_dev != 2'd3) begin
                e.dev = int'(req_dev); e.a0 = int'(req_a0); e.data = int'(req_data);
                mq.push_back(e);
            end
            if (ovf_clr) m_ovf = 1'b0;
        end
    endtask

    task automatic model_compare();
        bit act, awr_low;
        act     = cur_valid && cyc < cur_start + c_s + c_st + c_h;
        awr_low = act && cyc >= cur_start + c_s && cyc < cur_start + c_s + c_st;
        check("n_ym1_cs", n_ym1_cs, !(act && cur_dev == 0));
        check("n_ym2_cs", n_ym2_cs, !(act && cur_dev == 1));
        check("n_saa_cs", n_saa_cs, !(act && cur_dev == 2));
        check("n_awr", n_awr, !awr_low);
        check("ad_oe", ad_oe, act);
        if (act) begin
            check("ad_out", ad_out, cur_data);
            check("aa0", aa0, cur_a0);
        end else if (!rst_n) begin
            check("ad_out_rst", ad_out, 0);
            check("aa0_rst", aa0, 0);
        end
        check("busy", busy, (mq.size() > 0) || (cur_valid && cyc < free_edge - 1));
        check("req_rdy", req_rdy, mq.size() < c_depth);
        check("ovf", ovf, m_ovf);
    endtask

    initial begin
        forever begin
            @(posedge clk32);
            cyc++;
            if (!rst_n) model_reset();
            else model_edge();
            #1;
            model_compare();
        end
    end

    task automatic step(input bit wr, input int dev, input int a0, input int data, input bit clr);
        @(negedge clk32);
        req_wr   = wr;
        req_dev  = 2'(dev);
        req_a0   = a0[0];
        req_data = 8'(data);
        ovf_clr  = clr;
        @(posedge clk32);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            idle();
            k++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_n_awr", n_awr, 1);
        check("arst_cs", {n_saa_cs, n_ym2_cs, n_ym1_cs}, 7);
        check("arst_ad_oe", ad_oe, 0);
        idle();
        idle();
        @(negedge clk32);
        rst_n = 1'b1;
        idle();
        check("arst_req_rdy", req_rdy, 1);
        check("arst_busy", busy, 0);
    endtask

    int e0, rel, cs_fall, cs_rise, awr_fall, awr_rise, seen_data, seen_aa0, gap;
    bit seen1, got2;

    initial begin
        repeat (3) @(posedge clk32);
        #2;
        check("rst_n_awr", n_awr, 1);
        check("rst_cs", {n_saa_cs, n_ym2_cs, n_ym1_cs}, 7);
        check("rst_ad_oe", ad_oe, 0);
        check("rst_ad_out", ad_out, 0);
        check("rst_busy", busy, 0);
        check("rst_req_rdy", req_rdy, 1);
        check("rst_ovf", ovf, 0);
        @(negedge clk32);
        rst_n = 1'b1;

        // Single SAA write: edge offsets relative to the push edge.
        step(1'b1, 2, 1, 'hA5, 1'b0);
        e0 = cyc;
        cs_fall = -1; cs_rise = -1; awr_fall = -1; awr_rise = -1; seen_data = -1; seen_aa0 = -1;
        for (int i = 0; i < 20; i++) begin
            idle();
            rel = cyc - e0;
            if (!n_saa_cs && cs_fall < 0) cs_fall = rel;
            if (n_saa_cs && cs_fall >= 0 && cs_rise < 0) cs_rise = rel;
            if (!n_awr && awr_fall < 0) awr_fall = rel;
            if (n_awr && awr_fall >= 0 && awr_rise < 0) awr_rise = rel;
            if (!n_saa_cs && ad_oe) begin
                seen_data = int'(ad_out);
                seen_aa0  = int'(aa0);
            end
        end
        check("saa_cs_fall", cs_fall, 1);
        check("saa_cs_rise", cs_rise, 15);
        check("saa_awr_fall", awr_fall, 4);
        check("saa_awr_rise", awr_rise, 12);
        check("saa_data", seen_data, 'hA5);
        check("saa_aa0", seen_aa0, 1);
        check("saa_busy_end", busy, 0);

        // Fill, overflow, clear, then a request on the pop edge of a full FIFO.
        step(1'b1, 0, 0, 'h30, 1'b0);
        e0 = cyc;
        for (int i = 1; i < 7; i++) step(1'b1, i % 3, 0, 'h30 + i, 1'b0);
        check("ovf_set", ovf, 1);
        check("full_rdy", req_rdy, 0);
        step(1'b0, 0, 0, 0, 1'b1);
        check("ovf_clr", ovf, 0);
        while (cyc < e0 + 15) idle();
        step(1'b1, 2, 1, 'h77, 1'b0);
        check("pop_edge_drop_ovf", ovf, 1);
        check("pop_edge_rdy", req_rdy, 1);
        step(1'b1, 2, 1, 'h78, 1'b0);
        check("next_accept_rdy", req_rdy, 0);
        wait_idle(200);

        // dev 3 is discarded without trace.
        step(1'b0, 0, 0, 0, 1'b1);
        step(1'b1, 3, 1, 'h99, 1'b0);
        check("dev3_busy", busy, 0);
        check("dev3_ovf", ovf, 0);
        idle();
        check("dev3_cs", {n_saa_cs, n_ym2_cs, n_ym1_cs}, 7);

        // YM1 data write followed by YM2 address write.
        step(1'b1, 0, 1, 'h11, 1'b0);
        step(1'b1, 1, 0, 'h22, 1'b0);
        seen1 = 1'b0; got2 = 1'b0; gap = 0;
        for (int i = 0; i < 120 && !got2; i++) begin
            idle();
            if (!n_ym1_cs) seen1 = 1'b1;
            else if (seen1) begin
                if (!n_ym2_cs) got2 = 1'b1;
                else gap++;
            end
        end
        check("ym2_seen", got2, 1);
        check("ym_gap", gap, c_rec_en ? 1 + c_r : 1);
        wait_idle(200);

        // Asynchronous reset in the middle of a strobe with entries pending.
        step(1'b1, 2, 0, 'h5A, 1'b0);
        step(1'b1, 0, 0, 'h5B, 1'b0);
        step(1'b1, 1, 1, 'h5C, 1'b0);
        for (int i = 0; i < 40 && n_awr; i++) idle();
        check("strobe_reached", n_awr, 0);
        async_reset();

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 40, $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 255), $urandom_range(0, 19) == 0);
            if (i == 1500) async_reset();
        end
        idle();
        wait_idle(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
